// File: rtl/unit_dispatch_if.sv
// Request/response and unit-side bus for unit_dispatch.
// slave  : the dispatcher's view (accepts requests, drives the units).
// master : the thread plus execution units (issues requests, answers the units).
// The interface parameters must match the parameters of the unit_dispatch instance
// it is bound to.
interface unit_dispatch_if #(
    parameter int WORD_W  = 32,
    parameter int N_ARGS  = 3,
    parameter int N_UNITS = 4
);
    localparam int SEL_W = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;

    logic                        req_valid;
    logic                        req_ready;
    logic [SEL_W-1:0]            req_sel;
    logic [N_ARGS*WORD_W-1:0]    req_args;
    logic                        rsp_valid;
    logic [WORD_W-1:0]           rsp_data;
    logic                        rsp_err;
    logic [N_UNITS-1:0]          unit_valid;
    logic [N_ARGS*WORD_W-1:0]    unit_args;
    logic [N_UNITS-1:0]          unit_ack;
    logic [N_UNITS*WORD_W-1:0]   unit_data;

    modport slave (
        input  req_valid, req_sel, req_args, unit_ack, unit_data,
        output req_ready, rsp_valid, rsp_data, rsp_err, unit_valid, unit_args
    );

    modport master (
        output req_valid, req_sel, req_args, unit_ack, unit_data,
        input  req_ready, rsp_valid, rsp_data, rsp_err, unit_valid, unit_args
    );
endinterface

// File: rtl/unit_dispatch.sv
// unit_dispatch: single-outstanding dispatcher from a thread to one of several
// execution units. A request is accepted in IDLE, the chosen unit is driven with
// a one-hot valid in BUSY until it acks, and a one-cycle response is issued in RESP.
// Selector 0 is the null unit (immediate zero result); selectors >= N_UNITS
// return an immediate error without touching any unit.
// Optional feature: define UNIT_DISPATCH_TIMEOUT_EN to abort a BUSY phase that
// lasts TIMEOUT cycles without an ack (response data 0, err 1).
// All outputs are registered; rst is asynchronous and active-high.
module unit_dispatch #(
    parameter int WORD_W  = 32,
    parameter int N_ARGS  = 3,
    parameter int N_UNITS = 4,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    unit_dispatch_if.slave  bus
);
    localparam int SEL_W  = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
    localparam int ARGS_W = N_ARGS * WORD_W;
    // Unit count widened by one bit so out-of-range selectors compare cleanly.
    localparam logic [SEL_W:0] N_UNITS_EXT = (SEL_W + 1)'(N_UNITS);

`ifdef UNIT_DISPATCH_TIMEOUT_EN
    localparam int               CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Count value seen during the last permitted BUSY cycle.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t               state_r;
    logic [SEL_W-1:0]     sel_r;
    logic [ARGS_W-1:0]    args_r;
    logic                 req_ready_r;
    logic                 rsp_valid_r;
    logic [WORD_W-1:0]    rsp_data_r;
    logic                 rsp_err_r;
    logic [N_UNITS-1:0]   unit_valid_r;
`ifdef UNIT_DISPATCH_TIMEOUT_EN
    logic [CNT_W-1:0]     tmo_cnt_r;
`endif

    logic [N_UNITS-1:0]   req_onehot_s;
    logic [N_UNITS-1:0]   sel_onehot_s;
    logic                 req_bad_s;
    logic                 ack_hit_s;
    logic [WORD_W-1:0]    ack_data_s;

    // One-hot decode of a selector; the null unit (bit 0) and out-of-range
    // selectors decode to all zeros.
    function automatic logic [N_UNITS-1:0] sel_decode(input logic [SEL_W-1:0] sel);
        logic [N_UNITS-1:0] oh;
        oh = '0;
        for (int i = 1; i < N_UNITS; i++) begin
            oh[i] = (sel == SEL_W'(i));
        end
        return oh;
    endfunction

    // Decode the incoming selector and route the selected unit's ack and data.
    always_comb begin
        req_onehot_s = sel_decode(bus.req_sel);
        req_bad_s    = ({1'b0, bus.req_sel} >= N_UNITS_EXT);
        sel_onehot_s = sel_decode(sel_r);
        // Acks from other units, or outside BUSY, never reach the FSM.
        ack_hit_s    = (state_r == BUSY) && ((bus.unit_ack & sel_onehot_s) != '0);
        ack_data_s   = '0;
        for (int i = 0; i < N_UNITS; i++) begin
            ack_data_s = ack_data_s | (bus.unit_data[i*WORD_W +: WORD_W] & {WORD_W{sel_onehot_s[i]}});
        end
    end

    // Dispatch FSM with all outputs held in registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            sel_r        <= '0;
            args_r       <= '0;
            req_ready_r  <= 1'b1;
            rsp_valid_r  <= 1'b0;
            rsp_data_r   <= '0;
            rsp_err_r    <= 1'b0;
            unit_valid_r <= '0;
`ifdef UNIT_DISPATCH_TIMEOUT_EN
            tmo_cnt_r    <= '0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.req_valid && req_ready_r) begin
                        sel_r       <= bus.req_sel;
                        args_r      <= bus.req_args;
                        req_ready_r <= 1'b0;
                        if (req_onehot_s != '0) begin
                            state_r      <= BUSY;
                            unit_valid_r <= req_onehot_s;
`ifdef UNIT_DISPATCH_TIMEOUT_EN
                            tmo_cnt_r    <= '0;
`endif
                        end else begin
                            // Null unit or invalid selector: answer immediately.
                            state_r     <= RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_data_r  <= '0;
                            rsp_err_r   <= req_bad_s;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    // An ack on the final permitted cycle beats the timeout.
                    if (ack_hit_s) begin
                        state_r      <= RESP;
                        unit_valid_r <= '0;
                        rsp_valid_r  <= 1'b1;
                        rsp_data_r   <= ack_data_s;
                        rsp_err_r    <= 1'b0;
                    end
`ifdef UNIT_DISPATCH_TIMEOUT_EN
                    else if (tmo_cnt_r == TMO_LAST) begin
                        state_r      <= RESP;
                        unit_valid_r <= '0;
                        rsp_valid_r  <= 1'b1;
                        rsp_data_r   <= '0;
                        rsp_err_r    <= 1'b1;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
                    end
`else
                    else begin
                        state_r <= BUSY;
                    end
`endif
                end
                RESP: begin
                    // Response lasts one cycle; data and err return to zero with it.
                    state_r     <= IDLE;
                    req_ready_r <= 1'b1;
                    rsp_valid_r <= 1'b0;
                    rsp_data_r  <= '0;
                    rsp_err_r   <= 1'b0;
                end
                default: begin
                    state_r      <= IDLE;
                    req_ready_r  <= 1'b1;
                    rsp_valid_r  <= 1'b0;
                    rsp_data_r   <= '0;
                    rsp_err_r    <= 1'b0;
                    unit_valid_r <= '0;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_data   = rsp_data_r;
    assign bus.rsp_err    = rsp_err_r;
    assign bus.unit_valid = unit_valid_r;
    assign bus.unit_args  = args_r;
endmodule

// File: doc/unit_dispatch.md
UNIT_DISPATCH -- requirements
Module: unit_dispatch

Interface
REQ-001 SHALL have parameter WORD_W, default 32, width of each operand and result word.
REQ-002 SHALL have parameter N_ARGS, default 3, operand words per request; word 0 is the unit control word.
REQ-003 SHALL have parameter N_UNITS, default 4, selector space; index 0 is the null unit, indices 1..N_UNITS-1 are real units.
REQ-004 SHALL have parameter TIMEOUT, default 255, the maximum number of BUSY cycles without an ack.
REQ-005 SHALL have localparam SEL_W = $clog2(N_UNITS) (minimum 1).
REQ-006 clk  in  1  clock; all state changes occur on the rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 req_valid  in  1  the thread presents a request.
REQ-009 req_ready  out  1  the dispatcher accepts a request this cycle.
REQ-010 req_sel  in  SEL_W  target unit index.
REQ-011 req_args  in  N_ARGS*WORD_W  operands; word k occupies bits [k*WORD_W +: WORD_W].
REQ-012 rsp_valid  out  1  one-cycle completion pulse.
REQ-013 rsp_data  out  WORD_W  result, valid while rsp_valid is high.
REQ-014 rsp_err  out  1  error flag, qualified by rsp_valid.
REQ-015 unit_valid  out  N_UNITS  one-hot request to a unit; bit 0 is never set.
REQ-016 unit_args  out  N_ARGS*WORD_W  registered operands broadcast to all units.
REQ-017 unit_ack  in  N_UNITS  per-unit completion; the unit may ack in the same cycle its valid rises.
REQ-018 unit_data  in  N_UNITS*WORD_W  per-unit result, sampled with its ack.

Function
REQ-019 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-020 SHALL drive req_ready = 1 only in IDLE; a handshake occurs when req_valid && req_ready at a rising edge.
REQ-021 On handshake, SHALL register req_sel and req_args into sel_q and unit_args.
REQ-022 On handshake with 1 <= req_sel < N_UNITS, SHALL transition IDLE->BUSY.
REQ-023 On handshake with req_sel == 0 (null unit), SHALL transition IDLE->RESP with result 0 and err 0.
REQ-024 On handshake with req_sel >= N_UNITS, SHALL transition IDLE->RESP with result 0 and err 1, and no unit is driven.
REQ-025 In BUSY, SHALL drive unit_valid[sel_q] = 1 and all other bits 0; unit_args SHALL be held stable.
REQ-026 In BUSY, when unit_ack[sel_q] is high at an edge, SHALL capture unit_data[sel_q] and transition BUSY->RESP with err 0.
REQ-027 SHALL ignore acks from non-selected units, and acks in IDLE or RESP.
REQ-028 In RESP, SHALL drive rsp_valid = 1 for exactly one cycle with the registered data and err, then transition RESP->IDLE.
REQ-029 rsp_valid SHALL have no backpressure.
REQ-030 Latency for a zero-wait unit SHALL be: handshake at edge N, unit_valid high in cycle N+1, rsp_valid high in cycle N+2.
REQ-031 Latency for the null unit or an invalid selector SHALL be: rsp_valid high in cycle N+1.
REQ-032 Maximum throughput SHALL be one request per 3 cycles.
REQ-033 rsp_data and rsp_err SHALL be 0 whenever rsp_valid is 0.

Reset
REQ-034 While rst is asserted, SHALL hold state IDLE; req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, unit_valid=0, unit_args=0, sel_q=0, timeout counter=0.
REQ-035 Reset asserted mid-operation (BUSY or RESP) SHALL abort the operation immediately, with no rsp_valid pulse and unit_valid cleared asynchronously.

Configuration
REQ-036 With UNIT_DISPATCH_TIMEOUT_EN defined, SHALL count BUSY cycles in a $clog2(TIMEOUT+1)-bit counter that is cleared on entry to BUSY.
REQ-037 With UNIT_DISPATCH_TIMEOUT_EN defined, when the counter reaches TIMEOUT without an ack, SHALL transition BUSY->RESP with data 0 and err 1, and drop unit_valid.
REQ-038 With UNIT_DISPATCH_TIMEOUT_EN defined, an ack arriving in the same cycle the counter reaches TIMEOUT SHALL win (err 0, data captured).
REQ-039 Without UNIT_DISPATCH_TIMEOUT_EN, SHALL wait in BUSY indefinitely, implement no counter, and set err only for an invalid selector.

Verification
REQ-040 sel=1, args={0,5,3}, unit 1 acks combinationally with data 8 -> unit_valid=4'b0010 in N+1; rsp_valid, rsp_data=8, rsp_err=0 in N+2.
REQ-041 sel=0, args arbitrary -> no unit_valid; rsp_valid, rsp_data=0, rsp_err=0 in N+1.
REQ-042 N_UNITS=3 (SEL_W=2), sel=3 -> rsp_valid, rsp_err=1, rsp_data=0 in N+1; unit_valid stays 0.
REQ-043 sel=2, unit 2 acks after 4 cycles with 0xDEADBEEF, and unit 1 acks spuriously meanwhile -> unit_args stable; rsp_data=0xDEADBEEF; req_ready=0 throughout BUSY.
REQ-044 UNIT_DISPATCH_TIMEOUT_EN defined, TIMEOUT=4, no ack -> unit_valid drops after 4 BUSY cycles; rsp_err=1, rsp_data=0; a second run with ack on the 4th cycle -> rsp_err=0.
REQ-045 rst pulsed while in BUSY -> unit_valid=0 and req_ready=1 immediately; no rsp_valid pulse; the next request completes normally.
